// File: rtl/fc_pkg.sv
// Shared types and default sizing for the fully-connected datapath blocks.
package fc_pkg;

    localparam int DEF_WORD_SIZE         = 16;
    localparam int DEF_MEM_ADDRESS_WIDTH = 3;
    localparam int DEF_BUFFER_SIZE       = 120;

    typedef logic [DEF_WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dma_burst_reader.sv
// Single-channel read DMA: copies a burst of consecutive words from an
// asynchronous-read memory into a parallel buffer for the FC compute array.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_read; a start latches the length and clears o_buffer
// READ  | one word captured per cycle from o_mem_addr into buffer[idx]
// DONE  | o_ready high, buffer stable; leaves only once i_read drops
module dma_burst_reader
    import fc_pkg::*;
#(
    parameter int BUFFER_SIZE       = DEF_BUFFER_SIZE,
    parameter int WORD_SIZE         = DEF_WORD_SIZE,
    parameter int MEM_ADDRESS_WIDTH = DEF_MEM_ADDRESS_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_read,
    input  logic [MEM_ADDRESS_WIDTH-1:0]          i_address,
    input  logic [MEM_ADDRESS_WIDTH-1:0]          i_count,
    input  logic [WORD_SIZE-1:0]                  i_mem_data,
    output logic [MEM_ADDRESS_WIDTH-1:0]          o_mem_addr,
    output logic [0:BUFFER_SIZE-1][WORD_SIZE-1:0] o_buffer,
    output logic                                  o_ready
);

    // Index selects a buffer slot; the length counter must also hold the
    // full i_count range and the clamp value BUFFER_SIZE itself.
    localparam int IDX_W   = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int CNT_RAW = $clog2(BUFFER_SIZE + 1);
    localparam int CNT_W   = (MEM_ADDRESS_WIDTH > CNT_RAW) ? MEM_ADDRESS_WIDTH : CNT_RAW;

    state_e                                state_q, state_d;
    logic [MEM_ADDRESS_WIDTH-1:0]          addr_q, addr_d;
    logic [CNT_W-1:0]                      idx_q, idx_d;
    logic [CNT_W-1:0]                      len_q, len_d;
    logic [0:BUFFER_SIZE-1][WORD_SIZE-1:0] buf_q, buf_d;

    logic [CNT_W-1:0] count_ext;
    logic [CNT_W-1:0] len_clamped;
    logic             last_word;

    // Requested length, clamped so an oversized request never overruns the buffer.
    always_comb begin
        count_ext   = CNT_W'(i_count);
        len_clamped = (count_ext > CNT_W'(BUFFER_SIZE)) ? CNT_W'(BUFFER_SIZE) : count_ext;
        last_word   = (idx_q == (len_q - CNT_W'(1)));
    end

    // Next-state, address counter and buffer write decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (i_read) begin
                    len_d = len_clamped;
                    buf_d = '0;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = i_address;
                        idx_d   = '0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                buf_d[idx_q[IDX_W-1:0]] = i_mem_data;
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    idx_d  = idx_q + CNT_W'(1);
                    addr_d = addr_q + MEM_ADDRESS_WIDTH'(1);
                end
            end
            DONE: begin
                if (!i_read) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
        end
    end

    assign o_mem_addr = addr_q;
    assign o_buffer   = buf_q;
    assign o_ready    = (state_q == DONE);

endmodule

// File: tb/tb_dma_burst_reader.sv
// Directed bench for dma_burst_reader against a memory holding mem[i] = i.
module tb_dma_burst_reader;

    localparam int BS = 120;
    localparam int WS = 16;
    localparam int AW = 3;

    logic                          clk;
    logic                          reset;
    logic                          i_read;
    logic [AW-1:0]                 i_address;
    logic [AW-1:0]                 i_count;
    logic [WS-1:0]                 i_mem_data;
    logic [AW-1:0]                 o_mem_addr;
    logic [0:BS-1][WS-1:0]         o_buffer;
    logic                          o_ready;

    logic [WS-1:0] mem [0:(1<<AW)-1];

    int tests_run;
    int tests_failed;
    int cyc;

    dma_burst_reader #(
        .BUFFER_SIZE      (BS),
        .WORD_SIZE        (WS),
        .MEM_ADDRESS_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_read    (i_read),
        .i_address (i_address),
        .i_count   (i_count),
        .i_mem_data(i_mem_data),
        .o_mem_addr(o_mem_addr),
        .o_buffer  (o_buffer),
        .o_ready   (o_ready)
    );

    assign i_mem_data = mem[o_mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int nonzero_from(input int k);
        int n;
        n = 0;
        for (int i = k; i < BS; i++) begin
            if (o_buffer[i] != '0) n++;
        end
        return n;
    endfunction

    // Present a request and return just after the start edge.
    task automatic start(input int a, input int c);
        @(negedge clk);
        i_address = AW'(a);
        i_count   = AW'(c);
        i_read    = 1'b1;
        @(negedge clk);
    endtask

    // Cycles from the start edge until o_ready, bounded.
    task automatic wait_ready(input int max_cyc, output int n);
        n = 1;
        while (!o_ready && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) n = 999;
    endtask

    task automatic release_read();
        @(negedge clk);
        i_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = WS'(i);
        i_read    = 1'b0;
        i_address = '0;
        i_count   = '0;
        reset     = 1'b1;
        #35;
        check("rst_ready", {31'd0, o_ready}, 0);
        check("rst_addr", {29'd0, o_mem_addr}, 0);
        check("rst_buf_nz", nonzero_from(0), 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic burst: address 1, count 4
        start(1, 4);
        check("t1_addr_e1", {29'd0, o_mem_addr}, 1);
        check("t1_ready_e1", {31'd0, o_ready}, 0);
        for (int j = 2; j <= 4; j++) begin
            @(negedge clk);
            check($sformatf("t1_addr_e%0d", j), {29'd0, o_mem_addr}, j);
            check($sformatf("t1_ready_e%0d", j), {31'd0, o_ready}, 0);
        end
        @(negedge clk);
        check("t1_ready_e5", {31'd0, o_ready}, 1);
        check("t1_addr_e5", {29'd0, o_mem_addr}, 4);
        for (int k = 0; k < 4; k++) check($sformatf("t1_buf%0d", k), o_buffer[k], k + 1);
        check("t1_upper_nz", nonzero_from(4), 0);
        release_read();
        check("t1_ready_drop", {31'd0, o_ready}, 0);
        check("t1_buf_kept", o_buffer[3], 4);

        // Address wrap 6,7,0,1
        start(6, 4);
        wait_ready(20, cyc);
        check("t2_cycles", cyc, 5);
        check("t2_buf0", o_buffer[0], 6);
        check("t2_buf1", o_buffer[1], 7);
        check("t2_buf2", o_buffer[2], 0);
        check("t2_buf3", o_buffer[3], 1);
        release_read();

        // Zero length clears a previously filled buffer
        start(3, 0);
        check("t3_ready_1cyc", {31'd0, o_ready}, 1);
        check("t3_buf_nz", nonzero_from(0), 0);
        release_read();

        // Inputs change and i_read drops during READ
        start(0, 7);
        i_address = 3'd5;
        i_count   = 3'd2;
        i_read    = 1'b0;
        wait_ready(20, cyc);
        check("t4_cycles", cyc, 8);
        for (int k = 0; k < 7; k++) check($sformatf("t4_buf%0d", k), o_buffer[k], k);
        check("t4_upper_nz", nonzero_from(7), 0);
        @(negedge clk);
        @(negedge clk);

        // Async reset in the middle of READ
        start(1, 4);
        @(negedge clk);
        @(negedge clk);
        check("t5_pre_addr", {29'd0, o_mem_addr}, 3);
        #2;
        reset  = 1'b1;
        i_read = 1'b0;
        #1;
        check("t5_rst_ready", {31'd0, o_ready}, 0);
        check("t5_rst_addr", {29'd0, o_mem_addr}, 0);
        check("t5_rst_buf_nz", nonzero_from(0), 0);
        @(negedge clk);
        reset = 1'b0;
        start(3, 3);
        wait_ready(20, cyc);
        check("t5_cycles", cyc, 4);
        check("t5_buf0", o_buffer[0], 3);
        check("t5_buf1", o_buffer[1], 4);
        check("t5_buf2", o_buffer[2], 5);

        // Held request in DONE must not restart
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("t6_hold_ready%0d", j), {31'd0, o_ready}, 1);
            check($sformatf("t6_hold_addr%0d", j), {29'd0, o_mem_addr}, 5);
        end
        check("t6_hold_buf2", o_buffer[2], 5);
        release_read();
        start(2, 2);
        wait_ready(20, cyc);
        check("t6_cycles", cyc, 3);
        check("t6_buf0", o_buffer[0], 2);
        check("t6_buf1", o_buffer[1], 3);
        check("t6_upper_nz", nonzero_from(2), 0);
        release_read();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
